mp64_exwb: RTL
==============

MP64_EXWB -- requirements
Module: mp64_exwb

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of writeback buffer entries (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ex_valid input 1, ex_ready output 1: execute-to-writeback handshake.
REQ-005 SHALL have port ex_op  input  4  ALU opcode (mp64_pkg.vh encoding).
REQ-006 SHALL have port ex_rd  input  4  destination register index.
REQ-007 SHALL have port ex_result  input  64  ALU result.
REQ-008 SHALL have port ex_flags  input  8  ALU flags_out (bit0 Z, 1 C, 2 N, 3 V, 4 P, 5 G, 6 I, 7 S).
REQ-009 SHALL have port ex_setf  input  1  instruction updates flags.
REQ-010 SHALL have port wb_stall  input  1  register-file port busy; blocks retire.
REQ-011 SHALL have ports rf_we output 1, rf_waddr output 4, rf_wdata output 64: register-file write port.
REQ-012 SHALL have port flush  input  1  discard all buffered, unretired entries.
REQ-013 SHALL have ports csr_fwr input 1, csr_fdata input 2: write S,I (bits 7:6) of the flags register.
REQ-014 SHALL have port flags_q  output  8  architectural flags register.
REQ-015 SHALL have port flags_fwd  output  8  flags for the ALU flags_in: newest pending flags-setting entry merged with flags_q, else flags_q.
REQ-016 SHALL have ports fwd_hit output 1, fwd_data output 64, plus input fwd_rs 4: newest pending write to fwd_rs.

Function
REQ-017 SHALL buffer accepted entries in an in-order FIFO of DEPTH entries {op, rd, result, flags, setf}, with count 0..DEPTH.
REQ-018 SHALL drive ex_ready = (count < DEPTH) or a retire occurs this cycle; full-and-retiring accepts in the same cycle.
REQ-019 SHALL accept an entry on ex_valid & ex_ready; accept-to-earliest-retire latency is 1 cycle.
REQ-020 SHALL retire the head when count > 0 and !wb_stall, at most one entry per cycle.
REQ-021 SHALL drive rf_we combinationally = retire & (head.op != ALU_CMP); rf_waddr = head.rd; rf_wdata = head.result. CMP retires without a register write.
REQ-022 SHALL, on retire of an entry with setf=1, load flags_q[5:0] from head.flags[5:0]; flags_q[7:6] SHALL never change on retire.
REQ-023 SHALL load flags_q[7:6] from csr_fdata on csr_fwr, in the same edge as any retire update to bits 5:0.
REQ-024 SHALL compute flags_fwd = {flags_q[7:6], F[5:0]}, where F is the newest valid setf=1 entry, or flags_q[5:0] if none.
REQ-025 SHALL assert fwd_hit when any valid non-CMP entry has rd == fwd_rs, with fwd_data from the newest such entry; otherwise fwd_hit=0 and fwd_data=0.
REQ-026 SHALL, on flush, clear count and pointers at the next edge, suppress acceptance that cycle (ex_ready=0), and still perform the head retire (rf write, flags) if its retire condition holds.
REQ-027 SHALL wrap read and write pointers modulo DEPTH; simultaneous accept and retire SHALL leave count unchanged.
REQ-028 SHALL not change any state when ex_valid=0, count=0, csr_fwr=0 and flush=0.

Reset
REQ-029 SHALL, while rst_n=0, force count=0, pointers=0 and flags_q=8'h00, so that rf_we=0, fwd_hit=0, fwd_data=0, flags_fwd=8'h00 and ex_ready=1.
REQ-030 SHALL discard buffered entries and perform no register write when reset is asserted mid-operation.

Verification
REQ-031 Bench SHALL cover ADD with rd=3, result=300, setf=1, flags=8'h00 -> next cycle rf_we=1, waddr=3, wdata=300, then flags_q=8'h00.
REQ-032 Bench SHALL cover CMP with rd=5, result=0, flags=8'h03 -> no rf_we; flags_q=8'h03 after retire; flags_fwd=8'h03 while pending.
REQ-033 Bench SHALL cover wb_stall=1 with 3 entries offered -> DEPTH=2 accepted, ex_ready=0; on stall release, in-order retire with one write per cycle.
REQ-034 Bench SHALL cover two pending writes to r7 (11 then 22) with fwd_rs=7 -> fwd_hit=1, fwd_data=22.
REQ-035 Bench SHALL cover csr_fwr=1, csr_fdata=2'b11 concurrent with retire of flags 8'h3F -> flags_q=8'hFF.
REQ-036 Bench SHALL cover flush with 2 entries while stalled -> count=0, no rf_we; rst_n low mid-stream -> all outputs at reset values.

Source files
------------

// File: rtl/mp64_exwb.sv
// Execute-to-writeback buffer: in-order FIFO of ALU results that retires one
// entry per cycle into the register file and flags register, with operand and flags forwarding.
module mp64_exwb #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  logic [3:0]  ex_op,
   input  logic [3:0]  ex_rd,
   input  logic [63:0] ex_result,
   input  logic [7:0]  ex_flags,
   input  logic        ex_setf,
   input  logic        wb_stall,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [63:0] rf_wdata,
   input  logic        flush,
   input  logic        csr_fwr,
   input  logic [1:0]  csr_fdata,
   output logic [7:0]  flags_q,
   output logic [7:0]  flags_fwd,
   input  logic [3:0]  fwd_rs,
   output logic        fwd_hit,
   output logic [63:0] fwd_data
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] ALU_CMP = 4'h5;

   logic [3:0]  op_q   [DEPTH];
   logic [3:0]  rd_q   [DEPTH];
   logic [63:0] res_q  [DEPTH];
   logic [5:0]  fl_q   [DEPTH];
   logic        setf_q [DEPTH];

   logic [AW-1:0] wp, rp, idx;
   logic [AW:0]   count;
   logic          retire, accept;
   logic [5:0]    fwd_fl;
   logic          unused;

   // Only the arithmetic flags travel through the buffer; S and I come from the CSR path.
   assign unused = ^ex_flags[7:6];

   assign retire   = (count != '0) && !wb_stall;
   assign ex_ready = !flush && ((count < (AW+1)'(DEPTH)) || retire);
   assign accept   = ex_valid && ex_ready;

   assign rf_we    = retire && (op_q[rp] != ALU_CMP);
   assign rf_waddr = rd_q[rp];
   assign rf_wdata = res_q[rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp      <= '0;
         rp      <= '0;
         count   <= '0;
         flags_q <= 8'h00;
      end else begin
         if (retire && setf_q[rp]) flags_q[5:0] <= fl_q[rp];
         if (csr_fwr)              flags_q[7:6] <= csr_fdata;
         if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
         end else begin
            if (accept) wp <= wp + 1'b1;
            if (retire) rp <= rp + 1'b1;
            if (accept && !retire)      count <= count + 1'b1;
            else if (!accept && retire) count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         op_q[wp]   <= ex_op;
         rd_q[wp]   <= ex_rd;
         res_q[wp]  <= ex_result;
         fl_q[wp]   <= ex_flags[5:0];
         setf_q[wp] <= ex_setf;
      end
   end

   // Walk oldest to newest so the newest matching entry wins.
   always_comb begin
      idx      = '0;
      fwd_fl   = flags_q[5:0];
      fwd_hit  = 1'b0;
      fwd_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rp + AW'(i);
         if ((AW+1)'(i) < count) begin
            if (setf_q[idx]) fwd_fl = fl_q[idx];
            if (op_q[idx] != ALU_CMP && rd_q[idx] == fwd_rs) begin
               fwd_hit  = 1'b1;
               fwd_data = res_q[idx];
            end
         end
      end
   end

   assign flags_fwd = {flags_q[7:6], fwd_fl};
endmodule
